// File: rtl/rps_round_controller.sv
// -----------------------------------------------------------------------------
// rps_round_controller
//
// Round sequencer for the rock-paper-scissors arcade. Each round runs a
// countdown, opens a move window for the player, draws the machine move from
// a free-running LFSR and judges the outcome. The outcome is driven into the
// consecutive-win streak FSM, whose status is read back to decide whether to
// play another round or end the game.
//
// Optional feature macro: ROUND_TIMEOUT_EN
//   defined   : WAIT_MOVE expires after MOVE_WINDOW cycles with a forced lose.
//   undefined : no window counter; WAIT_MOVE waits for player_valid forever.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   start          in   begin a new game (sampled in IDLE or DONE)
//   player_valid   in   one-cycle strobe qualifying player_move
//   player_move    in   00 rock, 01 paper, 10 scissors, 11 invalid
//   streak_status  in   streak FSM status: 01 in progress, 11 won, 00 lost
//   streak_rst_n   out  active-low synchronous reset to the streak FSM
//   result         out  streak FSM input: 00 lose, 01 draw, 11 win
//   result_valid   out  single-cycle qualifier for a judged result
//   cpu_move       out  machine move of the current round
//   countdown      out  remaining countdown ticks
//   round_cnt      out  rounds judged this game, saturating at 15
//   phase          out  current state code
// -----------------------------------------------------------------------------
module rps_round_controller #(
    parameter int         TICK_DIV    = 1000,
    parameter int         COUNT_TICKS = 3,
    parameter int         MOVE_WINDOW = 2000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       player_valid,
    input  logic [1:0] player_move,
    input  logic [1:0] streak_status,
    output logic       streak_rst_n,
    output logic [1:0] result,
    output logic       result_valid,
    output logic [1:0] cpu_move,
    output logic [1:0] countdown,
    output logic [3:0] round_cnt,
    output logic [2:0] phase
);

    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_WAIT_MOVE = 3'd3,
        S_JUDGE     = 3'd4,
        S_REPORT    = 3'd5,
        S_SETTLE    = 3'd6,
        S_DONE      = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       move_q, move_d;
    logic             timeout_q, timeout_d;
    logic             streak_rst_n_q, streak_rst_n_d;
    logic [1:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [1:0]       cpu_move_q, cpu_move_d;
    logic [1:0]       countdown_q, countdown_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic             win_expired;
    logic [2:0]       diff_raw, diff_mod;
    logic [1:0]       judged;
    logic [1:0]       cpu_pick;

    // Move window: counts cycles spent in WAIT_MOVE, zero everywhere else, so
    // each window starts from 0 without an explicit clear.
`ifdef ROUND_TIMEOUT_EN
    localparam int WIN_W = $clog2(MOVE_WINDOW + 1);
    logic [WIN_W-1:0] win_q, win_d;

    always_comb begin
        win_d = '0;
        if (state_q == S_WAIT_MOVE) begin
            win_d = win_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_expired = (state_q == S_WAIT_MOVE) && (win_q == WIN_W'(MOVE_WINDOW - 1));
`else
    logic unused_window;
    assign win_expired   = 1'b0;
    assign unused_window = (MOVE_WINDOW != 0);
`endif

    // Machine move: first 2-bit field of the LFSR that is a legal move.
    always_comb begin
        if (lfsr_q[1:0] != 2'b11) begin
            cpu_pick = lfsr_q[1:0];
        end else if (lfsr_q[3:2] != 2'b11) begin
            cpu_pick = lfsr_q[3:2];
        end else begin
            cpu_pick = 2'b00;
        end
    end

    // (player - cpu) mod 3 with both operands in 0..2; the +3 bias keeps the
    // subtraction non-negative so one conditional correction is enough.
    always_comb begin
        diff_raw = 3'd3 + {1'b0, move_q} - {1'b0, cpu_move_q};
        diff_mod = (diff_raw >= 3'd3) ? diff_raw - 3'd3 : diff_raw;
        judged   = 2'b00;
        if (!timeout_q && move_q != 2'b11) begin
            if (diff_mod == 3'd1) begin
                judged = 2'b11;
            end else if (diff_mod == 3'd0) begin
                judged = 2'b01;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        div_d       = div_q;
        move_d      = move_q;
        timeout_d   = timeout_q;
        cpu_move_d  = cpu_move_q;
        countdown_d = countdown_q;
        round_cnt_d = round_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (div_q == DIV_W'(TICK_DIV - 1)) begin
                    div_d       = '0;
                    countdown_d = countdown_q - 1'b1;
                    if (countdown_q == 2'd1) begin
                        state_d    = S_WAIT_MOVE;
                        cpu_move_d = cpu_pick;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_WAIT_MOVE: begin
                // A strobe in the expiry cycle wins over the timeout.
                if (player_valid) begin
                    move_d    = player_move;
                    timeout_d = 1'b0;
                    state_d   = S_JUDGE;
                end else if (win_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_JUDGE;
                end
            end
            S_JUDGE: begin
                state_d = S_REPORT;
            end
            S_REPORT: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Anything but "in progress" (including 10) ends the game.
                if (streak_status == 2'b01) begin
                    state_d     = S_COUNTDOWN;
                    countdown_d = 2'(COUNT_TICKS);
                    div_d       = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) state_d = S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_ARM) begin
            countdown_d = 2'(COUNT_TICKS);
            round_cnt_d = '0;
            div_d       = '0;
        end
        if (state_d == S_REPORT && round_cnt_q != 4'hF) begin
            round_cnt_d = round_cnt_q + 1'b1;
        end

        // Outputs are decoded from the next state so the registered copies
        // line up with the state they describe.
        streak_rst_n_d = !(state_d == S_IDLE || state_d == S_ARM);
        result_valid_d = (state_d == S_REPORT);
        result_d       = (state_d == S_REPORT) ? judged : 2'b01;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lfsr_q         <= LFSR_SEED;
            div_q          <= '0;
            move_q         <= 2'b00;
            timeout_q      <= 1'b0;
            streak_rst_n_q <= 1'b0;
            result_q       <= 2'b01;
            result_valid_q <= 1'b0;
            cpu_move_q     <= 2'b00;
            countdown_q    <= 2'd0;
            round_cnt_q    <= 4'd0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            div_q          <= div_d;
            move_q         <= move_d;
            timeout_q      <= timeout_d;
            streak_rst_n_q <= streak_rst_n_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            cpu_move_q     <= cpu_move_d;
            countdown_q    <= countdown_d;
            round_cnt_q    <= round_cnt_d;
        end
    end

    assign streak_rst_n = streak_rst_n_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign cpu_move     = cpu_move_q;
    assign countdown    = countdown_q;
    assign round_cnt    = round_cnt_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_rps_round_controller.sv
// -----------------------------------------------------------------------------
// tb_rps_round_controller
//
// Self-checking bench for rps_round_controller with a behavioural streak FSM
// attached. A phase/elapsed-time reference model predicts every output each
// cycle; directed games pin the model with literal expectations, then a
// randomized stretch exercises ignored inputs, timeouts and resets.
// -----------------------------------------------------------------------------
module tb_rps_round_controller;

    localparam int         TD   = 4;
    localparam int         CT   = 3;
    localparam int         MW   = 10;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef ROUND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       player_valid = 1'b0;
    logic [1:0] player_move = 2'b00;
    logic [1:0] streak_status;
    logic       streak_rst_n;
    logic [1:0] result;
    logic       result_valid;
    logic [1:0] cpu_move;
    logic [1:0] countdown;
    logic [3:0] round_cnt;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rps_round_controller #(
        .TICK_DIV(TD), .COUNT_TICKS(CT), .MOVE_WINDOW(MW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .player_valid(player_valid), .player_move(player_move),
        .streak_status(streak_status), .streak_rst_n(streak_rst_n),
        .result(result), .result_valid(result_valid), .cpu_move(cpu_move),
        .countdown(countdown), .round_cnt(round_cnt), .phase(phase)
    );

    // Behavioural streak FSM: three wins -> won, any lose -> lost.
    logic [1:0] s_status = 2'b01;
    int         s_wins = 0;
    bit         inject10 = 1'b0;
    assign streak_status = inject10 ? 2'b10 : s_status;

    always @(posedge clk) begin
        if (!streak_rst_n) begin
            s_wins   <= 0;
            s_status <= 2'b01;
        end else if (s_status == 2'b01) begin
            if (result == 2'b11) begin
                s_wins <= s_wins + 1;
                if (s_wins == 2) s_status <= 2'b11;
            end else if (result == 2'b00) begin
                s_status <= 2'b00;
            end
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] pick(input logic [7:0] v);
        if (v[1:0] != 2'b11) return v[1:0];
        if (v[3:2] != 2'b11) return v[3:2];
        return 2'b00;
    endfunction

    // Rock 0, paper 1, scissors 2: paper beats rock, scissors beat paper,
    // rock beats scissors.
    function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
        if (p == 2'b11) return 2'b00;
        if (p == c) return 2'b01;
        if ((p == 2'd1 && c == 2'd0) || (p == 2'd2 && c == 2'd1) || (p == 2'd0 && c == 2'd2))
            return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] beats(input logic [1:0] c);
        case (c)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] loses_to(input logic [1:0] c);
        case (c)
            2'd0:    return 2'd2;
            2'd1:    return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    function automatic int next_phase(input int ph, input int el, input logic st,
                                      input logic pv, input logic [1:0] ss);
        case (ph)
            0, 7:    return st ? 1 : ph;
            1:       return 2;
            2:       return (el == CT * TD - 1) ? 3 : 2;
            3:       return (pv || (TO_EN && el == MW - 1)) ? 4 : 3;
            4:       return 5;
            5:       return 6;
            6:       return (ss == 2'b01) ? 2 : 7;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    int         m_phase = 0;
    int         m_elapsed = 0;
    int         m_rounds = 0;
    int         m_np;
    logic [1:0] m_cpu = 2'b00;
    logic [1:0] m_code = 2'b01;
    logic [7:0] m_lfsr = SEED;

    always_comb m_np = next_phase(m_phase, m_elapsed, start, player_valid, streak_status);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase   <= 0;
            m_elapsed <= 0;
            m_rounds  <= 0;
            m_cpu     <= 2'b00;
            m_code    <= 2'b01;
            m_lfsr    <= SEED;
        end else begin
            if (m_phase == 2 && m_np == 3) m_cpu <= pick(m_lfsr);
            if (m_phase == 3 && m_np == 4) m_code <= player_valid ? judge(player_move, m_cpu) : 2'b00;
            if (m_np == 5 && m_rounds < 15) m_rounds <= m_rounds + 1;
            if (m_np == 1) m_rounds <= 0;
            m_elapsed <= (m_np == m_phase) ? m_elapsed + 1 : 0;
            m_phase   <= m_np;
            m_lfsr    <= lfsr_next(m_lfsr);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_cd;
            exp_cd = (m_phase == 1) ? CT : (m_phase == 2) ? CT - m_elapsed / TD : 0;
            check("phase", 8'(phase), 8'(m_phase));
            check("streak_rst_n", 8'(streak_rst_n), 8'(m_phase > 1));
            check("result_valid", 8'(result_valid), 8'(m_phase == 5));
            check("result", 8'(result), 8'((m_phase == 5) ? m_code : 2'b01));
            check("cpu_move", 8'(cpu_move), 8'(m_cpu));
            check("countdown", 8'(countdown), 8'(exp_cd));
            check("round_cnt", 8'(round_cnt), 8'(m_rounds));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (phase !== 3'(p) && n < budget) begin
            cyc_wait(1);
            n++;
        end
        check("reach_phase", 8'(phase), 8'(p));
    endtask

    task automatic start_game();
        start = 1'b1;
        cyc_wait(1);
        start = 1'b0;
        check("arm_phase", 8'(phase), 8'd1);
        check("arm_streak_rst_n", 8'(streak_rst_n), 8'd0);
        wait_phase(3, 40);
    endtask

    // kind: 0 win, 1 draw, 2 lose. Called in WAIT_MOVE; ends in SETTLE.
    task automatic play(input int kind, input int delay, input bit hold,
                        input logic [1:0] exp_res);
        cyc_wait(delay);
        player_valid = 1'b1;
        player_move  = (kind == 0) ? beats(m_cpu) : (kind == 1) ? m_cpu : loses_to(m_cpu);
        cyc_wait(1);
        if (!hold) player_valid = 1'b0;
        check("judge_phase", 8'(phase), 8'd4);
        cyc_wait(1);
        player_valid = 1'b0;
        check("report_valid", 8'(result_valid), 8'd1);
        check("report_result", 8'(result), 8'(exp_res));
        cyc_wait(1);
        check("settle_phase", 8'(phase), 8'd6);
        check("settle_valid", 8'(result_valid), 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model itself with hand-computed values.
        check("model_lfsr_1", lfsr_next(8'hA5), 8'h4A);
        check("model_lfsr_2", lfsr_next(8'h4A), 8'h95);
        check("model_pick_fallback", 8'(pick(8'hFF)), 8'h00);
        check("model_pick_upper", 8'(pick(8'h0B)), 8'h02);
        check("model_judge_win", 8'(judge(2'd1, 2'd0)), 8'h03);
        check("model_judge_lose", 8'(judge(2'd0, 2'd1)), 8'h00);
        check("model_judge_invalid", 8'(judge(2'd3, 2'd2)), 8'h00);

        cyc_wait(2);
        chk_en = 1'b1;
        cyc_wait(1);
        reset = 1'b1;
        cyc_wait(1);
        check("rst_phase", 8'(phase), 8'd0);
        check("rst_streak_rst_n", 8'(streak_rst_n), 8'd0);
        check("rst_result", 8'(result), 8'd1);
        check("rst_countdown", 8'(countdown), 8'd0);

        // Game 1: countdown timing, then three straight wins.
        start = 1'b1;
        cyc_wait(1);
        start = 1'b0;
        check("g1_arm_phase", 8'(phase), 8'd1);
        check("g1_arm_rst_n", 8'(streak_rst_n), 8'd0);
        check("g1_arm_cd", 8'(countdown), 8'd3);
        cyc_wait(1);
        check("g1_cd_phase", 8'(phase), 8'd2);
        check("g1_cd_rst_n", 8'(streak_rst_n), 8'd1);
        check("g1_cd3", 8'(countdown), 8'd3);
        cyc_wait(3);
        check("g1_cd3_late", 8'(countdown), 8'd3);
        cyc_wait(1);
        check("g1_cd2", 8'(countdown), 8'd2);
        cyc_wait(4);
        check("g1_cd1", 8'(countdown), 8'd1);
        cyc_wait(4);
        check("g1_cd0", 8'(countdown), 8'd0);
        check("g1_wait_phase", 8'(phase), 8'd3);
        for (int r = 0; r < 3; r++) begin
            play(0, r, r == 1, 2'b11);
            cyc_wait(1);
            if (r < 2) begin
                check("g1_next_round", 8'(phase), 8'd2);
                wait_phase(3, 40);
            end
        end
        check("g1_done", 8'(phase), 8'd7);
        check("g1_rounds", 8'(round_cnt), 8'd3);
        check("g1_lights_on", 8'(streak_rst_n), 8'd1);

        // Game 2: lose ends the game straight from SETTLE.
        start_game();
        play(2, 2, 1'b0, 2'b00);
        cyc_wait(1);
        check("g2_done", 8'(phase), 8'd7);
        check("g2_rounds", 8'(round_cnt), 8'd1);

        // Game 3: draw keeps playing.
        start_game();
        play(1, 1, 1'b0, 2'b01);
        cyc_wait(1);
        check("g3_back_to_cd", 8'(phase), 8'd2);
        check("g3_rounds", 8'(round_cnt), 8'd1);
        wait_phase(3, 40);
        if (TO_EN) begin
            cyc_wait(MW - 1);
            check("to_still_waiting", 8'(phase), 8'd3);
            cyc_wait(1);
            check("to_judge", 8'(phase), 8'd4);
            cyc_wait(1);
            check("to_result", 8'(result), 8'd0);
            check("to_valid", 8'(result_valid), 8'd1);
            cyc_wait(2);
            check("to_done", 8'(phase), 8'd7);
            // Strobe in the expiry cycle: the move is judged.
            start_game();
            play(0, MW - 1, 1'b0, 2'b11);
        end else begin
            cyc_wait(3 * MW);
            check("no_to_waiting", 8'(phase), 8'd3);
            play(0, 0, 1'b0, 2'b11);
        end
        cyc_wait(1);
        check("expiry_continue", 8'(phase), 8'd2);

        // Round counter saturation through a long run of draws.
        for (int r = 0; r < 16; r++) begin
            wait_phase(3, 40);
            play(1, 0, 1'b0, 2'b01);
            cyc_wait(1);
        end
        check("round_sat", 8'(round_cnt), 8'd15);

        // Status 10 in SETTLE ends the game.
        wait_phase(3, 40);
        inject10 = 1'b1;
        play(1, 0, 1'b0, 2'b01);
        cyc_wait(1);
        check("status10_done", 8'(phase), 8'd7);
        inject10 = 1'b0;

        // Reset during WAIT_MOVE takes effect without a clock edge.
        start_game();
        cyc_wait(2);
        reset = 1'b0;
        #1;
        check("amid_rst_phase", 8'(phase), 8'd0);
        check("amid_rst_rst_n", 8'(streak_rst_n), 8'd0);
        check("amid_rst_result", 8'(result), 8'd1);
        check("amid_rst_valid", 8'(result_valid), 8'd0);
        check("amid_rst_cpu", 8'(cpu_move), 8'd0);
        check("amid_rst_cd", 8'(countdown), 8'd0);
        check("amid_rst_rounds", 8'(round_cnt), 8'd0);
        player_valid = 1'b1;
        cyc_wait(2);
        check("amid_rst_no_pulse", 8'(result_valid), 8'd0);
        player_valid = 1'b0;
        reset = 1'b1;
        cyc_wait(1);
        check("post_rst_idle", 8'(phase), 8'd0);

        // Randomized traffic: stray starts and strobes, timeouts, resets.
        for (int i = 0; i < 4000; i++) begin
            start        = ($urandom_range(0, 15) == 0);
            player_valid = ($urandom_range(0, 4) == 0);
            player_move  = 2'($urandom_range(0, 3));
            reset        = ($urandom_range(0, 999) != 0);
            cyc_wait(1);
        end
        reset        = 1'b1;
        start        = 1'b0;
        player_valid = 1'b0;
        cyc_wait(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
